// File: rtl/sync_demux_if.sv
// Stream and status bundle for the 1:2 synchronous demultiplexer.
// The demux takes the slave side; the producer/consumers take the master side.
interface sync_demux_if #(
    parameter int unsigned DW = 16,
    parameter int unsigned CW = 16
);
    logic [DW-1:0] x;
    logic          x_valid;
    logic          x_ready;
    logic          addr;
    logic [DW-1:0] y1;
    logic          y1_valid;
    logic          y1_ready;
    logic [DW-1:0] y2;
    logic          y2_valid;
    logic          y2_ready;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;

    modport slave (
        input  x, x_valid, addr, y1_ready, y2_ready,
        output x_ready, y1, y1_valid, y2, y2_valid, cnt1, cnt2
    );

    modport master (
        output x, x_valid, addr, y1_ready, y2_ready,
        input  x_ready, y1, y1_valid, y2, y2_valid, cnt1, cnt2
    );
endinterface

// File: rtl/sync_demux.sv
// 1:2 synchronous demultiplexer: one valid/ready input stream steered by addr
// into two independent FIFOs, each with its own accepted-word counter.
module sync_demux #(
    parameter int unsigned DW    = 16,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CW    = 16
) (
    input logic          sys_clk,
    input logic          sys_rst_n,
    sync_demux_if.slave  bus
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [DW-1:0] ch_head [2];
    logic [CW-1:0] ch_cnt  [2];
    logic [1:0]    ch_valid;
    logic [1:0]    ch_full;
    logic [1:0]    ch_ready;

    assign ch_ready = {bus.y2_ready, bus.y1_ready};

    // Ready looks only at the registered fill of the addressed FIFO, never at a same-cycle pop.
    assign bus.x_ready = !ch_full[bus.addr];

    for (genvar k = 0; k < 2; k++) begin : g_ch
        logic [DW-1:0] mem_q [DEPTH];
        logic [AW-1:0] wr_ptr_q;
        logic [AW-1:0] rd_ptr_q;
        logic [AW:0]   fill_q;
        logic [CW-1:0] cnt_q;
        logic          push;
        logic          pop;

        assign push = bus.x_valid && bus.x_ready && (bus.addr == 1'(k));
        assign pop  = ch_valid[k] && ch_ready[k];

        always_ff @(posedge sys_clk or negedge sys_rst_n) begin
            if (!sys_rst_n) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                fill_q   <= '0;
                cnt_q    <= '0;
            end else begin
                if (push) begin
                    wr_ptr_q <= wr_ptr_q + 1'b1;
                    cnt_q    <= cnt_q + 1'b1;
                end
                if (pop) begin
                    rd_ptr_q <= rd_ptr_q + 1'b1;
                end
                unique case ({push, pop})
                    2'b10:   fill_q <= fill_q + 1'b1;
                    2'b01:   fill_q <= fill_q - 1'b1;
                    default: fill_q <= fill_q;
                endcase
            end
        end

        // Storage is not reset; the fill count alone decides what is visible.
        always_ff @(posedge sys_clk) begin
            if (push) begin
                mem_q[wr_ptr_q] <= bus.x;
            end
        end

        assign ch_valid[k] = (fill_q != '0);
        assign ch_full[k]  = (fill_q == (AW + 1)'(DEPTH));
        assign ch_head[k]  = ch_valid[k] ? mem_q[rd_ptr_q] : '0;
        assign ch_cnt[k]   = cnt_q;
    end

    assign bus.y1       = ch_head[0];
    assign bus.y1_valid = ch_valid[0];
    assign bus.cnt1     = ch_cnt[0];
    assign bus.y2       = ch_head[1];
    assign bus.y2_valid = ch_valid[1];
    assign bus.cnt2     = ch_cnt[1];
endmodule
